udp_rx_pkt_buffer: RTL and testbench

- Sits directly downstream of the UDP receive parser, in the eth_rxc domain.
- Collects the parser's 32-bit payload words (rx_en/rx_data) into a circular data RAM.
- Commits a packet on rx_pkg_done only if its word count matches the UDP payload length; otherwise it discards the packet by rolling back the write pointer.
- Presents committed packets to the user as a valid/ready word stream with last, byte-keep and per-packet byte length.

---
 rtl/udp_rx_pkt_buffer_if.sv | 21 ++
 rtl/udp_rx_pkt_buffer.sv | 186 ++++++++++++++++++
 tb/tb_udp_rx_pkt_buffer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_pkt_buffer_if.sv
// Output stream bundle of the UDP receive packet buffer.
//   master (buffer side): m_data, m_valid, m_last, m_keep, m_byte_num out; m_ready in
//   slave  (consumer)   : the mirror image
interface udp_rx_pkt_buffer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [3:0]  m_keep;
  logic [15:0] m_byte_num;

  modport master (
    output m_data, m_valid, m_last, m_keep, m_byte_num,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_last, m_keep, m_byte_num,
    output m_ready
  );
endinterface

// File: rtl/udp_rx_pkt_buffer.sv
// UDP receive packet buffer (eth_rxc domain).
// Collects 32-bit payload words from the UDP parser into a circular RAM and
// commits a packet on rx_pkg_done only when its word count matches the UDP
// payload length; otherwise the write pointer rolls back to the last commit.
// Committed packets leave as a valid/ready stream with last, keep and length.
// Ports:
//   eth_rxc, rst_n      clock / async active-low reset
//   rx_pkg_done         end-of-frame pulse from the parser
//   rx_en, rx_data      payload word strobe and word (first byte in [31:24])
//   rx_byte_num         UDP payload byte count
//   m                   output stream (udp_rx_pkt_buffer_if.master)
//   pkt_cnt, drop_cnt   saturating committed / discarded packet counters
module udp_rx_pkt_buffer #(
  parameter int DATA_AW = 9,
  parameter int DESC_AW = 4
) (
  input  logic                       eth_rxc,
  input  logic                       rst_n,
  input  logic                       rx_pkg_done,
  input  logic                       rx_en,
  input  logic [31:0]                rx_data,
  input  logic [15:0]                rx_byte_num,
  udp_rx_pkt_buffer_if.master        m,
  output logic [15:0]                pkt_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int PW = DATA_AW + 1;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_e;

  // ---------------- write side ----------------
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, rd_ptr_nxt, wr_ptr_inc;
  logic [16:0]   word_cnt, word_cnt_new, exp_words;
  logic [15:0]   len, len_eff;
  logic          ovf, ovf_eff, buf_full, wr_fire, commit;
  logic          desc_full, desc_empty, desc_pop;

  // Full is judged on registered pointers only, so a word arriving in the
  // same cycle that a read frees a slot is still dropped.
  assign buf_full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign wr_fire      = rx_en && !buf_full;
  assign wr_ptr_inc   = wr_ptr + {{(PW-1){1'b0}}, wr_fire};
  assign word_cnt_new = word_cnt + {16'b0, wr_fire};
  // A word arriving with rx_pkg_done counts toward this frame's check.
  assign len_eff      = rx_en ? rx_byte_num : len;
  assign ovf_eff      = ovf || (rx_en && buf_full);
  assign exp_words    = ({1'b0, len_eff} + 17'd3) >> 2;
  assign commit       = rx_pkg_done && !ovf_eff && (word_cnt_new != 17'd0) &&
                        (word_cnt_new == exp_words) && !desc_full;

  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only so every
      // register samples pre-edge values regardless of statement order.
      wr_ptr     <= '0;
      commit_ptr <= '0;
      word_cnt   <= '0;
      ovf        <= 1'b0;
      len        <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      len <= len_eff;
      if (rx_pkg_done) begin
        word_cnt <= '0;
        ovf      <= 1'b0;
        if (commit) begin
          wr_ptr     <= wr_ptr_inc;
          commit_ptr <= wr_ptr_inc;
          if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
        end else begin
          wr_ptr <= commit_ptr;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end else begin
        wr_ptr   <= wr_ptr_inc;
        word_cnt <= word_cnt_new;
        ovf      <= ovf_eff;
      end
    end
  end

  // ---------------- data RAM ----------------
  logic [31:0] data_mem [2**DATA_AW];
  logic [31:0] ram_q;

  // The read address is the pointer as it will be after this edge, so ram_q
  // always holds the word at rd_ptr: a stall re-reads the same word and a
  // transfer prefetches the next one, giving one word per cycle.
  // NOTE: storage arrays carry no reset; stale contents are never output
  // because reads stay behind commit_ptr.
  always_ff @(posedge eth_rxc) begin
    if (wr_fire) data_mem[wr_ptr[DATA_AW-1:0]] <= rx_data;
    ram_q <= data_mem[rd_ptr_nxt[DATA_AW-1:0]];
  end

  // ---------------- descriptor FIFO (packet byte lengths) ----------------
  logic [15:0]     desc_mem [2**DESC_AW];
  logic [DESC_AW:0] desc_wp, desc_rp;
  logic [15:0]     desc_q;

  assign desc_empty = (desc_wp == desc_rp);
  assign desc_full  = ((desc_wp ^ desc_rp) == {1'b1, {DESC_AW{1'b0}}});
  assign desc_q     = desc_mem[desc_rp[DESC_AW-1:0]];

  always_ff @(posedge eth_rxc) begin
    if (commit) desc_mem[desc_wp[DESC_AW-1:0]] <= len_eff;
  end

  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      desc_wp <= '0;
      desc_rp <= '0;
    end else begin
      if (commit)   desc_wp <= desc_wp + 1'b1;
      if (desc_pop) desc_rp <= desc_rp + 1'b1;
    end
  end

  // ---------------- read FSM ----------------
  rd_state_e   state, state_nxt;
  logic [14:0] rem_words;
  logic [15:0] byte_num_q;
  logic        xfer, is_last, send;

  assign send    = (state == RD_SEND);
  assign xfer    = send && m.m_ready;
  assign is_last = (rem_words == 15'd1);
  assign rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, xfer};

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_nxt = state;
    desc_pop  = 1'b0;
    case (state)
      RD_IDLE:  if (!desc_empty) begin
                  desc_pop  = 1'b1;
                  state_nxt = RD_FETCH;
                end
      RD_FETCH: state_nxt = RD_SEND;
      RD_SEND:  if (xfer && is_last) state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RD_IDLE;
      rd_ptr     <= '0;
      rem_words  <= '0;
      byte_num_q <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (desc_pop) begin
        byte_num_q <= desc_q;
        // ceil(len/4) without a wider intermediate
        rem_words  <= {1'b0, desc_q[15:2]} + {14'b0, |desc_q[1:0]};
      end else if (xfer) begin
        rem_words  <= rem_words - 15'd1;
      end
    end
  end

  // ---------------- outputs ----------------
  logic [3:0] last_keep;

  always_comb begin
    last_keep = 4'b1111;
    case (byte_num_q[1:0])
      2'd1:    last_keep = 4'b1000;
      2'd2:    last_keep = 4'b1100;
      2'd3:    last_keep = 4'b1110;
      default: last_keep = 4'b1111;
    endcase
  end

  assign m.m_valid    = send;
  assign m.m_data     = send ? ram_q : 32'd0;
  assign m.m_last     = send && is_last;
  assign m.m_keep     = !send ? 4'b0000 : (is_last ? last_keep : 4'b1111);
  assign m.m_byte_num = byte_num_q;

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Directed bench for udp_rx_pkt_buffer. Three instances share the rx inputs,
// m_ready and reset: u0 default size, u1 with an 8-word RAM, u2 with a
// 2-entry descriptor FIFO. Each test resets all three and checks one of them.
module tb_udp_rx_pkt_buffer;
  logic        eth_rxc = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_pkg_done = 1'b0;
  logic        rx_en = 1'b0;
  logic [31:0] rx_data = '0;
  logic [15:0] rx_byte_num = '0;
  logic        m_ready = 1'b0;
  logic [15:0] pkt_cnt0, drop_cnt0, pkt_cnt1, drop_cnt1, pkt_cnt2, drop_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 eth_rxc = ~eth_rxc;

  udp_rx_pkt_buffer_if b0();
  udp_rx_pkt_buffer_if b1();
  udp_rx_pkt_buffer_if b2();
  assign b0.m_ready = m_ready;
  assign b1.m_ready = m_ready;
  assign b2.m_ready = m_ready;

  udp_rx_pkt_buffer #(.DATA_AW(9), .DESC_AW(4)) u0 (
    .eth_rxc(eth_rxc), .rst_n(rst_n), .rx_pkg_done(rx_pkg_done), .rx_en(rx_en),
    .rx_data(rx_data), .rx_byte_num(rx_byte_num), .m(b0.master),
    .pkt_cnt(pkt_cnt0), .drop_cnt(drop_cnt0));
  udp_rx_pkt_buffer #(.DATA_AW(3), .DESC_AW(4)) u1 (
    .eth_rxc(eth_rxc), .rst_n(rst_n), .rx_pkg_done(rx_pkg_done), .rx_en(rx_en),
    .rx_data(rx_data), .rx_byte_num(rx_byte_num), .m(b1.master),
    .pkt_cnt(pkt_cnt1), .drop_cnt(drop_cnt1));
  udp_rx_pkt_buffer #(.DATA_AW(9), .DESC_AW(1)) u2 (
    .eth_rxc(eth_rxc), .rst_n(rst_n), .rx_pkg_done(rx_pkg_done), .rx_en(rx_en),
    .rx_data(rx_data), .rx_byte_num(rx_byte_num), .m(b2.master),
    .pkt_cnt(pkt_cnt2), .drop_cnt(drop_cnt2));

  task automatic step();
    @(posedge eth_rxc);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [15:0] n, input logic done);
    rx_en = 1'b1;
    rx_data = d;
    rx_byte_num = n;
    rx_pkg_done = done;
    step();
    rx_en = 1'b0;
    rx_pkg_done = 1'b0;
  endtask

  task automatic done_pulse();
    rx_pkg_done = 1'b1;
    step();
    rx_pkg_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Counts u0 valid cycles over n cycles; any is a failure.
  task automatic quiet0(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      if (b0.m_valid) seen++;
      step();
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int idx, cyc, cnt;

    // ---- reset state ----
    do_reset();
    check("rst_valid", b0.m_valid, 0);
    check("rst_data", b0.m_data, 0);
    check("rst_keep", b0.m_keep, 0);
    check("rst_last", b0.m_last, 0);
    check("rst_bytes", b0.m_byte_num, 0);
    check("rst_pkt", pkt_cnt0, 0);
    check("rst_drop", drop_cnt0, 0);

    // ---- single 10-byte packet, latency and keep ----
    m_ready = 1'b1;
    push_word(32'hA1A2A3A4, 16'd10, 1'b0);
    push_word(32'hB1B2B3B4, 16'd10, 1'b0);
    push_word(32'hC1C20000, 16'd10, 1'b0);
    done_pulse();                      // edge 1: descriptor written
    check("t1_lat1", b0.m_valid, 0);
    step();                            // edge 2: RD_IDLE -> RD_FETCH
    check("t1_lat2", b0.m_valid, 0);
    step();                            // edge 3: data registered
    check("t1_lat3", b0.m_valid, 1);
    check("t1_w0", b0.m_data, 32'hA1A2A3A4);
    check("t1_k0", b0.m_keep, 4'b1111);
    check("t1_l0", b0.m_last, 0);
    check("t1_bytes", b0.m_byte_num, 16'd10);
    step();
    check("t1_w1", b0.m_data, 32'hB1B2B3B4);
    check("t1_k1", b0.m_keep, 4'b1111);
    check("t1_l1", b0.m_last, 0);
    step();
    check("t1_w2", b0.m_data, 32'hC1C20000);
    check("t1_k2", b0.m_keep, 4'b1100);
    check("t1_l2", b0.m_last, 1);
    step();
    check("t1_end", b0.m_valid, 0);
    check("t1_pkt", pkt_cnt0, 1);
    check("t1_drop", drop_cnt0, 0);

    // ---- short frame dropped, next packet reuses the same addresses ----
    do_reset();
    m_ready = 1'b1;
    push_word(32'h11111111, 16'd12, 1'b0);
    push_word(32'h22222222, 16'd12, 1'b0);
    done_pulse();
    quiet0("t2_quiet", 6);
    check("t2_drop", drop_cnt0, 1);
    check("t2_pkt0", pkt_cnt0, 0);
    check("t2_wrptr", u0.wr_ptr, 0);
    push_word(32'hD0000001, 16'd7, 1'b0);
    push_word(32'hD0000002, 16'd7, 1'b0);
    done_pulse();
    check("t2_commit", u0.commit_ptr, 2);
    idx = 0;
    while (!b0.m_valid && idx < 10) begin
      step();
      idx++;
    end
    check("t2_valid", b0.m_valid, 1);
    check("t2_w0", b0.m_data, 32'hD0000001);
    check("t2_l0", b0.m_last, 0);
    step();
    check("t2_w1", b0.m_data, 32'hD0000002);
    check("t2_k1", b0.m_keep, 4'b1110);
    check("t2_l1", b0.m_last, 1);
    check("t2_pkt", pkt_cnt0, 1);

    // ---- frame end with no payload ----
    do_reset();
    m_ready = 1'b1;
    done_pulse();
    check("t3_drop", drop_cnt0, 1);
    check("t3_wrptr", u0.wr_ptr, 0);
    quiet0("t3_quiet", 5);
    check("t3_pkt", pkt_cnt0, 0);

    // ---- back-pressure, ready pattern 1,0,0,1 ----
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h40000000 + i, 16'd32, 1'b0);
    done_pulse();
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 80) begin
      m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (b0.m_valid) begin
        check("t4_data", b0.m_data, 32'h40000000 + idx);
        check("t4_keep", b0.m_keep, 4'b1111);
        check("t4_last", b0.m_last, (idx == 7) ? 1 : 0);
        check("t4_bytes", b0.m_byte_num, 16'd32);
        if (m_ready) idx++;
      end
      step();
      cyc++;
    end
    check("t4_count", idx, 8);
    check("t4_end", b0.m_valid, 0);

    // ---- overflow on the 8-word RAM (u1) ----
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'hAA000000 + i, 16'd24, 1'b0);
    done_pulse();
    for (int i = 0; i < 4; i++) push_word(32'hBB000000 + i, 16'd16, 1'b0);
    done_pulse();
    check("t5_pkt", pkt_cnt1, 1);
    check("t5_drop", drop_cnt1, 1);
    check("t5_wrptr", u1.wr_ptr, 6);
    m_ready = 1'b1;
    cnt = 0;
    repeat (30) begin
      if (b1.m_valid) begin
        if (cnt < 6) check("t5_data", b1.m_data, 32'hAA000000 + cnt);
        cnt++;
      end
      step();
    end
    check("t5_count", cnt, 6);

    // ---- descriptor FIFO full on u2 (2 entries) ----
    // The first packet is popped into the read stage, the next two fill the
    // FIFO, so the fourth is the one dropped. Word and done share a cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_word(32'hCC000000 + i, 16'd4, 1'b1);
      step();
      step();
    end
    check("t6_pkt", pkt_cnt2, 3);
    check("t6_drop", drop_cnt2, 1);
    m_ready = 1'b1;
    cnt = 0;
    repeat (30) begin
      if (b2.m_valid) begin
        if (cnt < 3) check("t6_data", b2.m_data, 32'hCC000000 + cnt);
        check("t6_last", b2.m_last, 1);
        cnt++;
      end
      step();
    end
    check("t6_count", cnt, 3);

    // ---- reset in the middle of output ----
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hEE000000 + i, 16'd16, 1'b0);
    done_pulse();
    idx = 0;
    while (!b0.m_valid && idx < 10) begin
      step();
      idx++;
    end
    step();
    check("t7_mid", b0.m_data, 32'hEE000001);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid", b0.m_valid, 0);
    check("t7_data", b0.m_data, 0);
    check("t7_keep", b0.m_keep, 0);
    check("t7_last", b0.m_last, 0);
    check("t7_bytes", b0.m_byte_num, 0);
    check("t7_pkt", pkt_cnt0, 0);
    step();
    rst_n = 1'b1;
    quiet0("t7_quiet", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
